// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: selects the write-back value, commits it to
// the GPRs or HI/LO, and serves write-through combinational read ports plus a committed-write counter.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int HILO_IDX = 32,
  parameter int CNT_W    = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MEM_WB_MemtoReg,
  input  logic                  MEM_WB_RegWrite,
  input  logic [DATA_W-1:0]     MEM_WB_dm_out,
  input  logic [DATA_W-1:0]     MEM_WB_mux5_out,
  input  logic [5:0]            MEM_WB_mux1_out,
  input  logic [2*DATA_W-1:0]   MEM_WB_prod,
  input  logic [4:0]            rs_addr,
  input  logic [4:0]            rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic [DATA_W-1:0]     hi_data,
  output logic [DATA_W-1:0]     lo_data,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_gpr_we,
  output logic [CNT_W-1:0]      wb_count
);

  localparam logic [5:0] NREG_IDX = 6'(NREG);
  localparam logic [5:0] HILO_SEL = 6'(HILO_IDX);

  logic [DATA_W-1:0] gpr [0:NREG-1];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              gpr_wr;
  logic              hilo_wr;

  // Write-through read: a same-cycle GPR write to the addressed register is bypassed.
  // Index 32 never matches because the bypass compare includes the upper index bit.
  function automatic logic [DATA_W-1:0] read_gpr(
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr,
    input logic [5:0]        idx,
    input logic [DATA_W-1:0] wdata
  );
    if (addr == 5'd0)
      return '0;
    else if (wr && idx == {1'b0, addr})
      return wdata;
    else
      return stored;
  endfunction

  // Writes are suppressed while reset is held so neither the bypass nor wb_gpr_we can leak.
  always_comb begin
    wb_data   = MEM_WB_MemtoReg ? MEM_WB_dm_out : MEM_WB_mux5_out;
    gpr_wr    = reset && MEM_WB_RegWrite && (MEM_WB_mux1_out != 6'd0) && (MEM_WB_mux1_out < NREG_IDX);
    hilo_wr   = reset && MEM_WB_RegWrite && (MEM_WB_mux1_out == HILO_SEL);
    wb_gpr_we = gpr_wr;
  end

  always_comb begin
    rs_data = read_gpr(rs_addr, gpr[rs_addr], gpr_wr, MEM_WB_mux1_out, wb_data);
    rt_data = read_gpr(rt_addr, gpr[rt_addr], gpr_wr, MEM_WB_mux1_out, wb_data);
    hi_data = hilo_wr ? MEM_WB_prod[2*DATA_W-1:DATA_W] : hi_q;
    lo_data = hilo_wr ? MEM_WB_prod[DATA_W-1:0]        : lo_q;
  end

  // ---- commit stage: architectural state updates on the rising edge ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      wb_count <= '0;
    end else begin
      if (gpr_wr)
        gpr[MEM_WB_mux1_out[4:0]] <= wb_data;
      if (hilo_wr) begin
        hi_q <= MEM_WB_prod[2*DATA_W-1:DATA_W];
        lo_q <= MEM_WB_prod[DATA_W-1:0];
      end
      if (gpr_wr || hilo_wr)
        wb_count <= wb_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile, scored against an array-based model of the
// architectural state (32 GPRs, HI, LO, a modulo-16 commit counter).
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        MEM_WB_MemtoReg;
  logic        MEM_WB_RegWrite;
  logic [31:0] MEM_WB_dm_out;
  logic [31:0] MEM_WB_mux5_out;
  logic [5:0]  MEM_WB_mux1_out;
  logic [63:0] MEM_WB_prod;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [31:0] wb_data;
  logic        wb_gpr_we;
  logic [3:0]  wb_count;

  wb_regfile #(.DATA_W(32), .NREG(32), .HILO_IDX(32), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .MEM_WB_MemtoReg(MEM_WB_MemtoReg), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_dm_out(MEM_WB_dm_out), .MEM_WB_mux5_out(MEM_WB_mux5_out),
    .MEM_WB_mux1_out(MEM_WB_mux1_out), .MEM_WB_prod(MEM_WB_prod),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .hi_data(hi_data), .lo_data(lo_data),
    .wb_data(wb_data), .wb_gpr_we(wb_gpr_we), .wb_count(wb_count)
  );

  always #5 clock = ~clock;

  // Reference state
  logic [31:0] m_reg [0:31];
  logic [31:0] m_hi, m_lo;
  int          m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic gw,
                                             input logic [5:0] idx, input logic [31:0] wv);
    if (a == 5'd0) return 32'd0;
    if (gw && idx == {1'b0, a}) return wv;
    return m_reg[a];
  endfunction

  // One WB cycle: entered and left 1 time unit after a rising edge.
  task automatic step(input logic mtr, input logic rw, input logic [31:0] dm, input logic [31:0] alu,
                      input logic [5:0] idx, input logic [63:0] prod,
                      input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] exp_wb;
    logic        gw, hw;
    MEM_WB_MemtoReg = mtr;
    MEM_WB_RegWrite = rw;
    MEM_WB_dm_out   = dm;
    MEM_WB_mux5_out = alu;
    MEM_WB_mux1_out = idx;
    MEM_WB_prod     = prod;
    rs_addr         = ra;
    rt_addr         = rb;
    #2;
    exp_wb = mtr ? dm : alu;
    gw     = rw && idx >= 6'd1 && idx <= 6'd31;
    hw     = rw && idx == 6'd32;
    check_eq("wb_data",   wb_data,   exp_wb);
    check_eq("wb_gpr_we", wb_gpr_we, gw);
    check_eq("rs_data",   rs_data,   model_read(ra, gw, idx, exp_wb));
    check_eq("rt_data",   rt_data,   model_read(rb, gw, idx, exp_wb));
    check_eq("hi_data",   hi_data,   hw ? prod[63:32] : m_hi);
    check_eq("lo_data",   lo_data,   hw ? prod[31:0]  : m_lo);
    check_eq("wb_count",  wb_count,  m_cnt);
    @(posedge clock);
    #1;
    if (gw) m_reg[idx[4:0]] = exp_wb;
    if (hw) begin
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end
    if (gw || hw) m_cnt = (m_cnt + 1) % 16;
  endtask

  task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
    MEM_WB_RegWrite = 1'b0;
    rs_addr = ra;
    rt_addr = rb;
    #1;
  endtask

  initial begin
    logic [5:0]  ridx;
    logic [4:0]  ra, rb;
    model_clear();
    reset = 1'b0;
    step_inputs_reset: begin
      MEM_WB_MemtoReg = 1'b0;
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_dm_out   = 32'h0;
      MEM_WB_mux5_out = 32'h5555_AAAA;
      MEM_WB_mux1_out = 6'd5;
      MEM_WB_prod     = 64'h1111_2222_3333_4444;
      rs_addr         = 5'd5;
      rt_addr         = 5'd5;
    end
    // Reset held with a live write: nothing visible, nothing commits.
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_rs", rs_data, 32'd0);
    check_eq("rst_rt", rt_data, 32'd0);
    check_eq("rst_hi", hi_data, 32'd0);
    check_eq("rst_lo", lo_data, 32'd0);
    check_eq("rst_cnt", wb_count, 4'd0);
    check_eq("rst_we", wb_gpr_we, 1'b0);
    MEM_WB_RegWrite = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rel_gpr5", rs_data, 32'd0);
    check_eq("rel_cnt", wb_count, 4'd0);

    // ALU write then load write to GPR7.
    step(1'b0, 1'b1, 32'h0, 32'h1234_5678, 6'd7, 64'h0, 5'd7, 5'd0);
    idle_read(5'd7, 5'd7);
    check_eq("alu_gpr7", rs_data, 32'h1234_5678);
    check_eq("alu_cnt", wb_count, 4'd1);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 6'd7, 64'h0, 5'd7, 5'd3);
    idle_read(5'd7, 5'd7);
    check_eq("ld_gpr7", rt_data, 32'hDEAD_BEEF);
    check_eq("ld_cnt", wb_count, 4'd2);

    // Write-through on both ports before the edge (step checks rs/rt pre-edge).
    step(1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 6'd9, 64'h0, 5'd9, 5'd9);
    idle_read(5'd9, 5'd0);
    check_eq("wt_gpr9", rs_data, 32'hA5A5_A5A5);

    // HI/LO: bypassed during the cycle, registered after; GPR0 stays zero.
    step(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 6'd32, 64'h0000_0001_FFFF_FFFE, 5'd0, 5'd0);
    idle_read(5'd0, 5'd0);
    check_eq("hl_hi", hi_data, 32'h1);
    check_eq("hl_lo", lo_data, 32'hFFFF_FFFE);
    check_eq("hl_gpr0", rs_data, 32'd0);

    // Ignored writes.
    step(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 6'd0,  64'h0, 5'd0, 5'd7);
    step(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 6'd40, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 5'd7);
    step(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 6'd7,  64'h0, 5'd7, 5'd8);
    step(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 6'd32, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 5'd0);
    idle_read(5'd7, 5'd0);
    check_eq("ign_gpr7", rs_data, 32'hDEAD_BEEF);
    check_eq("ign_hi", hi_data, 32'h1);
    check_eq("ign_cnt", wb_count, 4'd4);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       ridx = 6'd32;
        1:       ridx = 6'($urandom_range(33, 63));
        default: ridx = 6'($urandom_range(0, 31));
      endcase
      ra = ($urandom_range(0, 2) == 0) ? ridx[4:0] : 5'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ridx[4:0] : 5'($urandom);
      step(1'($urandom), ($urandom_range(0, 3) != 0), $urandom, $urandom, ridx,
           {$urandom, $urandom}, ra, rb);
    end

    // Counter wrap: 17 commits from a fresh reset land on 1.
    reset = 1'b0;
    #1;
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 17; n++)
      step(1'b0, 1'b1, 32'h0, 32'h100 + 32'(n), (n % 2 == 0) ? 6'd11 : 6'd32,
           {32'(n), 32'(n)}, 5'd11, 5'd12);
    idle_read(5'd11, 5'd0);
    check_eq("wrap_cnt", wb_count, 4'd1);
    check_eq("wrap_gpr11", rs_data, 32'h110);

    // Asynchronous reset mid-cycle with a write pending: immediate clear, write lost.
    MEM_WB_RegWrite = 1'b1;
    MEM_WB_mux1_out = 6'd12;
    reset = 1'b0;
    #1;
    rs_addr = 5'd11;
    #1;
    check_eq("ar_cnt", wb_count, 4'd0);
    check_eq("ar_gpr11", rs_data, 32'd0);
    check_eq("ar_hi", hi_data, 32'd0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 6'd0, 64'h0, 5'd12, 5'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
